// File: rtl/jk_counter_if.sv
// Bus bundle for jk_counter: control/data inputs and registered state outputs.
interface jk_counter_if #(
  parameter int WIDTH = 32'd8
);
  logic             en_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] j_i;
  logic [WIDTH-1:0] k_i;
  logic [WIDTH-1:0] d_i;
  logic [WIDTH-1:0] q_o;
  logic             wrap_o;

  // Driver side: issues operations and observes the cell state.
  modport master (
    output en_i, mode_i, j_i, k_i, d_i,
    input  q_o, wrap_o
  );

  // Counter side: consumes operations and presents the cell state.
  modport slave (
    input  en_i, mode_i, j_i, k_i, d_i,
    output q_o, wrap_o
  );
endinterface

// File: rtl/jk_counter.sv
// jk_counter: WIDTH independent JK cells that can also act together as an
// up/down counter (wrapping or saturating) or be parallel-loaded.
// wrap_o flags, one cycle late, every enabled up-count from all-ones or
// down-count from zero, whether or not the count actually wrapped.
module jk_counter #(
  parameter int          WIDTH     = 32'd8,
  parameter int unsigned RESET_VAL = 32'd0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic         clk,
  input  logic         rst_i,
  jk_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_q_s;
  logic             next_wrap_s;
  mode_e            mode_s;

  assign mode_s     = mode_e'(bus.mode_i);
  assign bus.q_o    = q_r;
  assign bus.wrap_o = wrap_r;

  // Next-state selection for the cells and the terminal-count flag.
  always_comb begin
    next_q_s    = q_r;
    next_wrap_s = 1'b0;
    if (bus.en_i) begin
      case (mode_s)
        MODE_JK: begin
          // Per bit: J sets, K clears, both toggle, neither holds.
          next_q_s = (bus.j_i & ~q_r) | (~bus.k_i & q_r);
        end
        MODE_UP: begin
          if (q_r == ALL_ONES) begin
            next_wrap_s = 1'b1;
            if (SATURATE) begin
              next_q_s = q_r;
            end else begin
              next_q_s = ALL_ZERO;
            end
          end else begin
            next_q_s = q_r + ONE;
          end
        end
        MODE_DOWN: begin
          if (q_r == ALL_ZERO) begin
            next_wrap_s = 1'b1;
            if (SATURATE) begin
              next_q_s = q_r;
            end else begin
              next_q_s = ALL_ONES;
            end
          end else begin
            next_q_s = q_r - ONE;
          end
        end
        MODE_LOAD: begin
          next_q_s = bus.d_i;
        end
        default: begin
          next_q_s = q_r;
        end
      endcase
    end else begin
      next_q_s    = q_r;
      next_wrap_s = 1'b0;
    end
  end

  // State register with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      q_r    <= RST_Q;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= next_q_s;
      wrap_r <= next_wrap_s;
    end
  end

endmodule
